// File: rtl/audioqsys_led_pio_blink.sv
// audioqsys_led_pio_blink
// Avalon-MM output PIO for board LEDs. It provides a DATA register with atomic
// SET, CLR and TOGGLE write ports. Selected bits blink under a programmable
// half-period prescaler. Reads have zero latency.
module audioqsys_led_pio_blink #(
   parameter int unsigned WIDTH        = 9,
   parameter int unsigned PERIOD_W     = 24,
   parameter int unsigned RESET_VALUE  = 0,
   parameter int unsigned RESET_PERIOD = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [WIDTH-1:0]    RST_DATA   = WIDTH'(RESET_VALUE);
   localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(RESET_PERIOD);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_BLINK  = 3'd1;
   localparam logic [2:0] ADDR_SET    = 3'd2;
   localparam logic [2:0] ADDR_CLR    = 3'd3;
   localparam logic [2:0] ADDR_TOGGLE = 3'd4;
   localparam logic [2:0] ADDR_PERIOD = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;

   logic [WIDTH-1:0]    data;
   logic [WIDTH-1:0]    blink;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] cnt;
   logic                phase;

   logic                wr;
   logic [WIDTH-1:0]    wd;
   logic [PERIOD_W-1:0] wd_period;
   logic                period_wr;
   logic                terminal;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign wd_period = writedata[PERIOD_W-1:0];
   assign period_wr = wr && (address == ADDR_PERIOD);
   assign terminal  = (cnt == period - PERIOD_W'(1));

   // DATA and BLINK registers, including the read-modify-write atomics.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data  <= RST_DATA;
         blink <= '0;
      end else if (wr) begin
         case (address)
            ADDR_DATA:   data  <= wd;
            ADDR_BLINK:  blink <= wd;
            ADDR_SET:    data  <= data | wd;
            ADDR_CLR:    data  <= data & ~wd;
            ADDR_TOGGLE: data  <= data ^ wd;
            default:     ;
         endcase
      end
   end

   // The PERIOD register and the blink prescaler. A PERIOD write always restarts
   // the prescaler from cnt 0 and phase 0, even on a terminal-count cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period <= RST_PERIOD;
         cnt    <= '0;
         phase  <= 1'b0;
      end else if (period_wr) begin
         period <= wd_period;
         cnt    <= '0;
         phase  <= 1'b0;
      end else if (period == '0) begin
         cnt    <= '0;
         phase  <= 1'b0;
      end else if (terminal) begin
         cnt    <= '0;
         phase  <= ~phase;
      end else begin
         cnt    <= cnt + PERIOD_W'(1);
      end
   end

   // Zero-latency read mux. It is not gated by chipselect, and unused bits read as zero.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:   readdata = 32'(data);
         ADDR_BLINK:  readdata = 32'(blink);
         ADDR_PERIOD: readdata = 32'(period);
         ADDR_STATUS: readdata = {31'd0, phase};
         default:     readdata = '0;
      endcase
   end

   // A blinking bit is driven high only during the high phase of the prescaler.
   assign out_port = data & (~blink | {WIDTH{phase}});

endmodule

// File: tb/tb_audioqsys_led_pio_blink.sv
// tb_audioqsys_led_pio_blink
// Table-driven register checks, followed by hand-written blink, period and reset sequences.
module tb_audioqsys_led_pio_blink;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [8:0]  out_port;

   int compared   = 0;
   int mismatched = 0;

   audioqsys_led_pio_blink #(
      .WIDTH(9), .PERIOD_W(24), .RESET_VALUE(32'h0A5), .RESET_PERIOD(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  wr_addr;
      logic [31:0] wdata;
      logic [2:0]  rd_addr;
      logic [31:0] exp_read;
      logic [8:0]  exp_out;
   } vec_t;

   // Compare one value and record the result.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // A one-cycle bus write. It is called just after a negedge and returns just after the next negedge.
   task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = addr;
      writedata  = data;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   // Read a register combinationally after the address settles.
   task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
      address = addr;
      #1;
      data = readdata;
   endtask

   vec_t        vecs[$];
   logic [31:0] rd;
   logic [8:0]  exp_o;
   logic        ph;

   initial begin
      // Register vectors: {we, wr_addr, wdata, rd_addr, exp_read, exp_out}
      vecs.push_back('{1'b0, 3'd0, 32'h0,        3'd0, 32'h0A5,    9'h0A5});
      vecs.push_back('{1'b0, 3'd0, 32'h0,        3'd1, 32'h0,      9'h0A5});
      vecs.push_back('{1'b0, 3'd0, 32'h0,        3'd5, 32'h0,      9'h0A5});
      vecs.push_back('{1'b0, 3'd0, 32'h0,        3'd6, 32'h0,      9'h0A5});
      vecs.push_back('{1'b1, 3'd0, 32'hFFFFFFFF, 3'd0, 32'h1FF,    9'h1FF});
      vecs.push_back('{1'b1, 3'd0, 32'h0F0,      3'd0, 32'h0F0,    9'h0F0});
      vecs.push_back('{1'b1, 3'd2, 32'h003,      3'd0, 32'h0F3,    9'h0F3});
      vecs.push_back('{1'b1, 3'd3, 32'h030,      3'd0, 32'h0C3,    9'h0C3});
      vecs.push_back('{1'b1, 3'd4, 32'h101,      3'd0, 32'h1C2,    9'h1C2});
      vecs.push_back('{1'b0, 3'd0, 32'h0,        3'd2, 32'h0,      9'h1C2});
      vecs.push_back('{1'b0, 3'd0, 32'h0,        3'd3, 32'h0,      9'h1C2});
      vecs.push_back('{1'b0, 3'd0, 32'h0,        3'd4, 32'h0,      9'h1C2});
      vecs.push_back('{1'b1, 3'd7, 32'hFFFF,     3'd7, 32'h0,      9'h1C2});
      vecs.push_back('{1'b1, 3'd6, 32'hFFFF,     3'd6, 32'h0,      9'h1C2});
      vecs.push_back('{1'b1, 3'd1, 32'h003,      3'd1, 32'h003,    9'h1C0});
      vecs.push_back('{1'b1, 3'd1, 32'hFFFFFFFF, 3'd1, 32'h1FF,    9'h000});
      vecs.push_back('{1'b1, 3'd1, 32'h0,        3'd1, 32'h0,      9'h1C2});
      vecs.push_back('{1'b1, 3'd5, 32'hFF000004, 3'd5, 32'h000004, 9'h1C2});
      vecs.push_back('{1'b1, 3'd5, 32'h0,        3'd5, 32'h0,      9'h1C2});
      vecs.push_back('{1'b0, 3'd0, 32'h0,        3'd0, 32'h1C2,    9'h1C2});

      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         if (vecs[i].we) applyStimulus(vecs[i].wr_addr, vecs[i].wdata);
         readReg(vecs[i].rd_addr, rd);
         checkOutput($sformatf("vec%0d readdata", i), rd, vecs[i].exp_read);
         checkOutput($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
      end

      // Blink sequence with PERIOD=4: bit 0 is low for 4 clocks, then high for 4 clocks.
      applyStimulus(3'd0, 32'h1FF);
      applyStimulus(3'd1, 32'h001);
      applyStimulus(3'd5, 32'd4);
      address = 3'd6;
      for (int k = 0; k < 16; k++) begin
         #1;
         ph = ((k / 4) % 2) == 1;
         checkOutput($sformatf("blink4 k%0d out_port", k), 32'(out_port), {23'd0, 8'hFF, ph});
         checkOutput($sformatf("blink4 k%0d status", k), readdata, {31'd0, ph});
         @(negedge clk);
      end
      // Move to k=21, where the phase is high with cnt=1.
      repeat (5) @(negedge clk);
      #1;
      checkOutput("blink4 k21 out_port", 32'(out_port), 32'h1FF);

      // Writing PERIOD=0 in the middle of a blink forces the phase low and holds it there.
      applyStimulus(3'd5, 32'd0);
      for (int k = 0; k < 5; k++) begin
         #1;
         checkOutput($sformatf("stop k%0d out_port", k), 32'(out_port), 32'h1FE);
         @(negedge clk);
      end

      // PERIOD=2 restarts from cnt 0 and toggles every 2 clocks.
      applyStimulus(3'd5, 32'd2);
      for (int k = 0; k < 9; k++) begin
         #1;
         ph = ((k / 2) % 2) == 1;
         checkOutput($sformatf("blink2 k%0d out_port", k), 32'(out_port), {23'd0, 8'hFF, ph});
         @(negedge clk);
      end
      // At k=9, cnt=1 and the next edge is a terminal count. A PERIOD write on that edge must keep the phase low.
      #1;
      checkOutput("blink2 k9 out_port", 32'(out_port), 32'h1FE);
      applyStimulus(3'd5, 32'd2);
      exp_o = 9'h1FE;
      for (int k = 0; k < 3; k++) begin
         #1;
         exp_o = (k == 2) ? 9'h1FF : 9'h1FE;
         checkOutput($sformatf("tcwrite k%0d out_port", k), 32'(out_port), 32'(exp_o));
         @(negedge clk);
      end

      // An asynchronous reset in the middle of a blink restores the reset values at once.
      applyStimulus(3'd1, 32'h0F0);
      reset_n = 1'b0;
      #1;
      checkOutput("async reset out_port", 32'(out_port), 32'h0A5);
      readReg(3'd1, rd);
      checkOutput("async reset blink", rd, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      readReg(3'd0, rd);
      checkOutput("post reset data", rd, 32'h0A5);
      readReg(3'd5, rd);
      checkOutput("post reset period", rd, 32'h0);
      address = 3'd6;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         checkOutput($sformatf("post reset k%0d status", k), readdata, 32'h0);
         checkOutput($sformatf("post reset k%0d out_port", k), 32'(out_port), 32'h0A5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
